// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// default bus widths and grant-source constants.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// Saturating count of consecutive data grants made while fetch waits;
// at_max tells the arbiter to let fetch through next.
module mem_arb_streak_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam logic [3:0] MAX_L = 4'(MAX);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc && (cnt_q != MAX_L)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_L);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Optional perf counters are built when MEM_PORT_ARBITER_PERF_EN is defined.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              flush,
  output logic              fetch_ack,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]       perf_fetch_grants,
  output logic [31:0]       perf_data_grants,
  output logic [31:0]       perf_conflict_cycles
`endif
);

  arb_state_e state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              fetch_ack_q, fetch_ack_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d;
  logic              data_ack_q, data_ack_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              discard_q, discard_d;

  logic is_idle, gnt_data, gnt_fetch, gnt_src, streak_at_max;

  // Data wins unless fetch has already waited out a full streak.
  assign is_idle   = (state_q == IDLE);
  assign gnt_data  = is_idle && data_req && !(fetch_req && streak_at_max);
  assign gnt_fetch = is_idle && !gnt_data && fetch_req && !flush;
  assign gnt_src   = gnt_data ? GNT_DATA : GNT_FETCH;

  mem_arb_streak_ctr #(
    .MAX (MAX_DATA_STREAK)
  ) u_streak (
    .clk    (clk),
    .rst    (rst),
    .clr    (gnt_fetch || (is_idle && !fetch_req)),
    .inc    (gnt_data && fetch_req),
    .at_max (streak_at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_data)       state_d = BUSY_D;
        else if (gnt_fetch) state_d = BUSY_F;
      end
      BUSY_F:  if (mem_ack) state_d = IDLE;
      BUSY_D:  if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    fetch_ack_d   = 1'b0;
    fetch_valid_d = 1'b0;
    fetch_rdata_d = fetch_rdata_q;
    data_ack_d    = 1'b0;
    data_rdata_d  = data_rdata_q;
    discard_d     = discard_q;
    case (state_q)
      IDLE: begin
        if (gnt_data || gnt_fetch) begin
          mem_req_d = 1'b1;
          if (gnt_src == GNT_DATA) begin
            mem_we_d    = data_we;
            mem_addr_d  = data_addr;
            mem_wdata_d = data_wdata;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = fetch_addr;
          end
        end
      end
      BUSY_F: begin
        if (flush) discard_d = 1'b1;
        // A flush landing on the completion cycle still invalidates the fetch.
        if (mem_ack) begin
          mem_req_d     = 1'b0;
          fetch_ack_d   = 1'b1;
          fetch_valid_d = !(discard_q || flush);
          fetch_rdata_d = mem_rdata;
          discard_d     = 1'b0;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          data_ack_d   = 1'b1;
          data_rdata_d = mem_rdata;
        end
      end
      default: mem_req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      fetch_ack_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_rdata_q <= '0;
      data_ack_q    <= 1'b0;
      data_rdata_q  <= '0;
      discard_q     <= 1'b0;
    end else begin
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch_ack_q   <= fetch_ack_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_ack_q    <= data_ack_d;
      data_rdata_q  <= data_rdata_d;
      discard_q     <= discard_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign fetch_ack   = fetch_ack_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_rdata = fetch_rdata_q;
  assign data_ack    = data_ack_q;
  assign data_rdata  = data_rdata_q;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] pf_fetch_q, pf_fetch_d, pf_data_q, pf_data_d, pf_conf_q, pf_conf_d;

  // Both requesters high always means one of them is waiting.
  always_comb begin
    pf_fetch_d = pf_fetch_q + {31'd0, gnt_fetch};
    pf_data_d  = pf_data_q + {31'd0, gnt_data};
    pf_conf_d  = pf_conf_q + {31'd0, (fetch_req && data_req)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pf_fetch_q <= '0;
      pf_data_q  <= '0;
      pf_conf_q  <= '0;
    end else begin
      pf_fetch_q <= pf_fetch_d;
      pf_data_q  <= pf_data_d;
      pf_conf_q  <= pf_conf_d;
    end
  end

  assign perf_fetch_grants    = pf_fetch_q;
  assign perf_data_grants     = pf_data_q;
  assign perf_conflict_cycles = pf_conf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch-only, priority, streak,
// flush and mid-transaction reset scenarios.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        flush;
  logic        fetch_ack;
  logic        fetch_valid;
  logic [15:0] fetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;
  logic        data_ack;
  logic [15:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_fetch_grants, perf_data_grants, perf_conflict_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W          (16),
    .DATA_W          (16),
    .MAX_DATA_STREAK (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .flush       (flush),
    .fetch_ack   (fetch_ack),
    .fetch_valid (fetch_valid),
    .fetch_rdata (fetch_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_ack    (data_ack),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    .perf_fetch_grants    (perf_fetch_grants),
    .perf_data_grants     (perf_data_grants),
    .perf_conflict_cycles (perf_conflict_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, ".fetch_ack"}, 32'(fetch_ack), 32'h0);
    chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'h0);
    chk({tag, ".fetch_rdata"}, 32'(fetch_rdata), 32'h0);
    chk({tag, ".data_ack"}, 32'(data_ack), 32'h0);
    chk({tag, ".data_rdata"}, 32'(data_rdata), 32'h0);
  endtask

  logic [15:0] exp_addr [6];

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk_all_reset("reset");
    rst = 1'b0;
    tick();

    // 1: fetch only, memory acks 2 cycles after mem_req
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    tick();
    chk("t1.mem_req", 32'(mem_req), 32'h1);
    chk("t1.mem_we", 32'(mem_we), 32'h0);
    chk("t1.mem_addr", 32'(mem_addr), 32'h0010);
    tick();
    chk("t1.mem_req_hold", 32'(mem_req), 32'h1);
    chk("t1.no_early_ack", 32'(fetch_ack), 32'h0);
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    chk("t1.fetch_ack", 32'(fetch_ack), 32'h1);
    chk("t1.fetch_valid", 32'(fetch_valid), 32'h1);
    chk("t1.fetch_rdata", 32'(fetch_rdata), 32'hBEEF);
    chk("t1.mem_req_drop", 32'(mem_req), 32'h0);
    fetch_req = 1'b0;
    tick();
    chk("t1.ack_pulse", 32'(fetch_ack), 32'h0);
    chk("t1.no_reissue", 32'(mem_req), 32'h0);

    // 2: simultaneous fetch and store, store wins
    fetch_req = 1'b1; fetch_addr = 16'h0020;
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h8000; data_wdata = 16'h1234;
    tick();
    chk("t2.mem_req", 32'(mem_req), 32'h1);
    chk("t2.store_we", 32'(mem_we), 32'h1);
    chk("t2.store_addr", 32'(mem_addr), 32'h8000);
    chk("t2.store_wdata", 32'(mem_wdata), 32'h1234);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t2.data_ack", 32'(data_ack), 32'h1);
    chk("t2.no_fetch_ack", 32'(fetch_ack), 32'h0);
    data_req = 1'b0; data_we = 1'b0;
    tick();
    chk("t2.fetch_we", 32'(mem_we), 32'h0);
    chk("t2.fetch_addr", 32'(mem_addr), 32'h0020);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    chk("t2.fetch_ack", 32'(fetch_ack), 32'h1);
    chk("t2.fetch_rdata", 32'(fetch_rdata), 32'h5555);
    fetch_req = 1'b0;
    tick();

    // 3: data streak limit of 4, then fetch, then data resumes
    exp_addr[0] = 16'h0100; exp_addr[1] = 16'h0100; exp_addr[2] = 16'h0100;
    exp_addr[3] = 16'h0100; exp_addr[4] = 16'h0030; exp_addr[5] = 16'h0100;
    fetch_req = 1'b1; fetch_addr = 16'h0030;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t3.grant%0d_addr", i), 32'(mem_addr), 32'(exp_addr[i]));
      chk($sformatf("t3.grant%0d_req", i), 32'(mem_req), 32'h1);
      mem_ack = 1'b1; mem_rdata = 16'(16'h0A00 + i);
      tick();
      mem_ack = 1'b0;
      chk($sformatf("t3.grant%0d_data_ack", i), 32'(data_ack), (i == 4) ? 32'h0 : 32'h1);
      if (i == 4) fetch_addr = 16'h0031;
    end
    data_req = 1'b0;
    tick();
    chk("t3.pending_fetch", 32'(mem_addr), 32'h0031);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t3.fetch_ack", 32'(fetch_ack), 32'h1);
    fetch_req = 1'b0;
    tick();

    // 4: flush after fetch grant; flush in IDLE blocks grant; flush on ack cycle
    fetch_req = 1'b1; fetch_addr = 16'h0040;
    tick();
    chk("t4.mem_req", 32'(mem_req), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hAAAA;
    tick();
    mem_ack = 1'b0;
    chk("t4.flushed_ack", 32'(fetch_ack), 32'h1);
    chk("t4.flushed_valid", 32'(fetch_valid), 32'h0);
    fetch_addr = 16'h0050; flush = 1'b1;
    tick();
    chk("t4.idle_flush_blocks", 32'(mem_req), 32'h0);
    flush = 1'b0;
    tick();
    chk("t4.next_fetch_addr", 32'(mem_addr), 32'h0050);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    chk("t4.next_valid", 32'(fetch_valid), 32'h1);
    chk("t4.next_rdata", 32'(fetch_rdata), 32'h7777);
    fetch_addr = 16'h0060;
    tick();
    mem_ack = 1'b1; flush = 1'b1;
    tick();
    mem_ack = 1'b0; flush = 1'b0;
    chk("t4.ack_flush_same_ack", 32'(fetch_ack), 32'h1);
    chk("t4.ack_flush_same_valid", 32'(fetch_valid), 32'h0);
    fetch_req = 1'b0;
    tick();

    // 5: flush held during data load
    flush = 1'b1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0042;
    tick();
    chk("t5.mem_req", 32'(mem_req), 32'h1);
    chk("t5.mem_addr", 32'(mem_addr), 32'h0042);
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hC0DE;
    tick();
    mem_ack = 1'b0;
    chk("t5.data_ack", 32'(data_ack), 32'h1);
    chk("t5.data_rdata", 32'(data_rdata), 32'hC0DE);
    data_req = 1'b0; flush = 1'b0;
    tick();

    // 6: reset while BUSY_D, stale ack afterwards
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h9000; data_wdata = 16'hFFFF;
    tick();
    chk("t6.busy", 32'(mem_req), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; data_req = 1'b0; data_we = 1'b0;
    chk_all_reset("t6.after_rst");
    mem_ack = 1'b1; mem_rdata = 16'h3333;
    tick();
    mem_ack = 1'b0;
    chk_all_reset("t6.stale_ack");
    tick();
    chk("t6.quiet_data_ack", 32'(data_ack), 32'h0);
    chk("t6.quiet_mem_req", 32'(mem_req), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
